mdu_iterative: RTL

- Parametrised, multi-cycle RV32M multiply/divide unit. Decodes funct3 for all eight M-extension operations and computes the result iteratively, one bit per cycle.
- Sits beside the single-cycle ALU. The control path asserts start when funct7 = 0000001 on an R-type instruction.
- Uses a start/busy/done handshake so the core can stall while an operation is in flight.

---
 rtl/mdu_iterative.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
// mdu_iterative : RV32M multiply/divide unit, one result bit per clock,
//                 start/busy/done handshake so the core can stall on it.
// Revision      : 1.0
// ============================================================================
module mdu_iterative #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              a_signed, b_signed, in_sa, in_sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, accept;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step, prod_fix;
  logic [XLEN+1:0]   div_shift, div_diff;
  logic [XLEN:0]     rem_step;
  logic [XLEN-1:0]   quo_step, quo_fix, rem_fix, calc_result;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    in_sa    = a_signed & op_a[XLEN-1];
    in_sb    = b_signed & op_b[XLEN-1];
    mag_a    = in_sa ? -op_a : op_a;
    mag_b    = in_sb ? -op_b : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (op_a == INT_MIN) && (op_b == '1);
    accept   = start && (((state_q == S_IDLE) && !flush) || (state_q == S_DONE));

    // Multiply: acc = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_step = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: dividend bits shift out of acc low half, quotient bits shift in
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = div_shift - {2'b00, opnd_q};
    rem_step  = div_diff[XLEN+1] ? div_shift[XLEN:0] : div_diff[XLEN:0];
    quo_step  = {acc_q[XLEN-2:0], ~div_diff[XLEN+1]};

    prod_fix = (sign_a_q ^ sign_b_q) ? -mul_step : mul_step;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -quo_step : quo_step;
    rem_fix  = sign_a_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];

    case (funct3_q)
      3'b000:                 calc_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calc_result = quo_fix;
      default:                calc_result = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    funct3_d = funct3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (funct3_q[2]) begin
            acc_d = {acc_q[2*XLEN-1:XLEN], quo_step};
            rem_d = rem_step;
          end else begin
            acc_d = mul_step;
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = S_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = calc_result;
          end
        end
      end
      default: begin
        if (accept) begin
          funct3_d = funct3;
          sign_a_d = in_sa;
          sign_b_d = in_sb;
          acc_d    = {{XLEN{1'b0}}, mag_a};
          rem_d    = '0;
          opnd_d   = mag_b;
          cnt_d    = CNT_W'(XLEN);
          if (div_zero || div_ovf) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (div_zero) result_d = funct3[1] ? op_a : '1;
            else          result_d = funct3[1] ? '0 : op_a;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      funct3_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      funct3_q <= funct3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire
